// File: rtl/line_transfer_engine_pkg.sv
// Shared bus command encoding for the line transfer engine and its bus neighbours.
package line_transfer_engine_pkg;

    localparam int BUS_COMMAND_WIDTH = 2;

    typedef enum logic [BUS_COMMAND_WIDTH-1:0] {
        NONE          = 2'd0,
        BUS_READ      = 2'd1,
        BUS_WRITEBACK = 2'd2
    } busCommands;

endpackage

// File: rtl/line_transfer_engine.sv
// Line transfer engine: optionally writes back a victim cache block word by word,
// then fills the requested block critical-word-first and installs its tag/state.
// Outputs are registered, decoded from the next state so they line up with it.
module line_transfer_engine
    import line_transfer_engine_pkg::*;
#(
    parameter int TAG_WIDTH     = 8,
    parameter int INDEX_WIDTH   = 4,
    parameter int OFFSET_WIDTH  = 2,
    parameter int STATE_WIDTH   = 2,
    parameter int INVALID_STATE = 0
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic                                       writeBack,
    input  logic                                       fill,
    input  logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] address,
    input  logic [TAG_WIDTH-1:0]                       victimTag,
    input  logic [STATE_WIDTH-1:0]                     fillState,
    input  logic                                       abort,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       aborted,
    output logic                                       arbiterRequest,
    input  logic                                       arbiterGrant,
    output logic [BUS_COMMAND_WIDTH-1:0]               busCommandOut,
    output logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] masterAddress,
    output logic                                       masterReadEnabled,
    output logic                                       masterWriteEnabled,
    input  logic                                       masterFunctionComplete,
    output logic [OFFSET_WIDTH-1:0]                    cacheOffset,
    output logic                                       cacheWriteData,
    output logic                                       cacheWriteTag,
    output logic                                       cacheWriteState,
    output logic [STATE_WIDTH-1:0]                     cacheStateIn
);

    localparam int ADDRESS_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;
    localparam logic [STATE_WIDTH-1:0]  INVALID_CODE = STATE_WIDTH'(INVALID_STATE);
    localparam logic [OFFSET_WIDTH-1:0] LAST_WORD    = {OFFSET_WIDTH{1'b1}};
    localparam logic [OFFSET_WIDTH-1:0] FIRST_WORD   = {OFFSET_WIDTH{1'b0}};

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_WB_GRANT   = 4'd1;
    localparam logic [3:0] S_WB_WAIT    = 4'd2;
    localparam logic [3:0] S_WB_NEXT    = 4'd3;
    localparam logic [3:0] S_FILL_GRANT = 4'd4;
    localparam logic [3:0] S_FILL_WAIT  = 4'd5;
    localparam logic [3:0] S_FILL_WRITE = 4'd6;
    localparam logic [3:0] S_UPDATE     = 4'd7;
    localparam logic [3:0] S_FINISH     = 4'd8;

    // True for the three write-back states.
    function automatic logic is_wb_state(input logic [3:0] s);
        return (s == S_WB_GRANT) || (s == S_WB_WAIT) || (s == S_WB_NEXT);
    endfunction

    // True for the three fill states.
    function automatic logic is_fill_state(input logic [3:0] s);
        return (s == S_FILL_GRANT) || (s == S_FILL_WAIT) || (s == S_FILL_WRITE);
    endfunction

    logic [3:0]              state_r;
    logic [OFFSET_WIDTH-1:0] count_r;
    logic                    fill_r;
    logic                    aborted_r;
    logic [TAG_WIDTH-1:0]    tag_r;
    logic [TAG_WIDTH-1:0]    victim_tag_r;
    logic [INDEX_WIDTH-1:0]  index_r;
    logic [OFFSET_WIDTH-1:0] start_offset_r;
    logic [STATE_WIDTH-1:0]  fill_state_r;

    logic [3:0]              state_next_s;
    logic [OFFSET_WIDTH-1:0] count_next_s;
    logic                    aborted_next_s;
    logic                    capture_s;

    logic                    fill_next_s;
    logic [TAG_WIDTH-1:0]    tag_next_s;
    logic [TAG_WIDTH-1:0]    victim_tag_next_s;
    logic [INDEX_WIDTH-1:0]  index_next_s;
    logic [OFFSET_WIDTH-1:0] start_offset_next_s;
    logic [STATE_WIDTH-1:0]  fill_state_next_s;
    logic [OFFSET_WIDTH-1:0] fill_offset_next_s;

    logic                         busy_s;
    logic                         done_s;
    logic                         aborted_s;
    logic [BUS_COMMAND_WIDTH-1:0] bus_command_s;
    logic [ADDRESS_WIDTH-1:0]     master_address_s;
    logic                         master_read_s;
    logic                         master_write_s;
    logic [OFFSET_WIDTH-1:0]      cache_offset_s;
    logic                         cache_write_data_s;
    logic                         cache_write_tag_s;
    logic                         cache_write_state_s;
    logic [STATE_WIDTH-1:0]       cache_state_in_s;

    // Next-state, word counter and abort-flag logic; abort wins over a word completion.
    always_comb begin
        state_next_s   = state_r;
        count_next_s   = count_r;
        aborted_next_s = aborted_r;
        capture_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    capture_s      = 1'b1;
                    count_next_s   = FIRST_WORD;
                    aborted_next_s = 1'b0;
                    if (writeBack) begin
                        state_next_s = S_WB_GRANT;
                    end else if (fill) begin
                        state_next_s = S_FILL_GRANT;
                    end else begin
                        state_next_s = S_FINISH;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_WB_GRANT: begin
                if (abort) begin
                    state_next_s   = S_FINISH;
                    aborted_next_s = 1'b1;
                end else if (arbiterGrant) begin
                    state_next_s = S_WB_WAIT;
                end else begin
                    state_next_s = S_WB_GRANT;
                end
            end
            S_WB_WAIT: begin
                if (abort) begin
                    state_next_s   = S_FINISH;
                    aborted_next_s = 1'b1;
                end else if (masterFunctionComplete) begin
                    state_next_s = S_WB_NEXT;
                end else begin
                    state_next_s = S_WB_WAIT;
                end
            end
            S_WB_NEXT: begin
                if (abort) begin
                    state_next_s   = S_FINISH;
                    aborted_next_s = 1'b1;
                end else if (count_r == LAST_WORD) begin
                    if (fill_r) begin
                        count_next_s = FIRST_WORD;
                        state_next_s = S_FILL_GRANT;
                    end else begin
                        state_next_s = S_UPDATE;
                    end
                end else begin
                    count_next_s = count_r + OFFSET_WIDTH'(1);
                    state_next_s = S_WB_GRANT;
                end
            end
            S_FILL_GRANT: begin
                if (arbiterGrant) begin
                    state_next_s = S_FILL_WAIT;
                end else begin
                    state_next_s = S_FILL_GRANT;
                end
            end
            S_FILL_WAIT: begin
                if (masterFunctionComplete) begin
                    state_next_s = S_FILL_WRITE;
                end else begin
                    state_next_s = S_FILL_WAIT;
                end
            end
            S_FILL_WRITE: begin
                if (count_r == LAST_WORD) begin
                    state_next_s = S_UPDATE;
                end else begin
                    count_next_s = count_r + OFFSET_WIDTH'(1);
                    state_next_s = S_FILL_GRANT;
                end
            end
            S_UPDATE: begin
                state_next_s = S_FINISH;
            end
            S_FINISH: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
                count_next_s = FIRST_WORD;
            end
        endcase
    end

    // Request fields as they will be held after this edge (captured on an accepted start).
    always_comb begin
        if (capture_s) begin
            fill_next_s         = fill;
            tag_next_s          = address[ADDRESS_WIDTH-1 -: TAG_WIDTH];
            index_next_s        = address[OFFSET_WIDTH+INDEX_WIDTH-1 -: INDEX_WIDTH];
            start_offset_next_s = address[OFFSET_WIDTH-1:0];
            victim_tag_next_s   = victimTag;
            fill_state_next_s   = fillState;
        end else begin
            fill_next_s         = fill_r;
            tag_next_s          = tag_r;
            index_next_s        = index_r;
            start_offset_next_s = start_offset_r;
            victim_tag_next_s   = victim_tag_r;
            fill_state_next_s   = fill_state_r;
        end
        // Critical-word-first: wraps at the counter width.
        fill_offset_next_s = start_offset_next_s + count_next_s;
    end

    // Output decode of the next state, to be registered alongside it.
    always_comb begin
        busy_s              = (state_next_s != S_IDLE);
        done_s              = (state_next_s == S_FINISH);
        aborted_s           = (state_next_s == S_FINISH) && aborted_next_s;
        master_write_s      = (state_next_s == S_WB_WAIT);
        master_read_s       = (state_next_s == S_FILL_WAIT);
        cache_write_data_s  = (state_next_s == S_FILL_WRITE);
        cache_write_state_s = (state_next_s == S_UPDATE);
        cache_write_tag_s   = (state_next_s == S_UPDATE) && fill_next_s;
        if (is_wb_state(state_next_s)) begin
            bus_command_s    = BUS_WRITEBACK;
            master_address_s = {victim_tag_next_s, index_next_s, count_next_s};
            cache_offset_s   = count_next_s;
        end else if (is_fill_state(state_next_s)) begin
            bus_command_s    = BUS_READ;
            master_address_s = {tag_next_s, index_next_s, fill_offset_next_s};
            cache_offset_s   = fill_offset_next_s;
        end else begin
            bus_command_s    = NONE;
            master_address_s = {tag_next_s, index_next_s, fill_offset_next_s};
            cache_offset_s   = fill_offset_next_s;
        end
        if ((state_next_s == S_UPDATE) && fill_next_s) begin
            cache_state_in_s = fill_state_next_s;
        end else begin
            cache_state_in_s = INVALID_CODE;
        end
    end

    // State, counter, captured request and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r            <= S_IDLE;
            count_r            <= FIRST_WORD;
            fill_r             <= 1'b0;
            aborted_r          <= 1'b0;
            tag_r              <= {TAG_WIDTH{1'b0}};
            victim_tag_r       <= {TAG_WIDTH{1'b0}};
            index_r            <= {INDEX_WIDTH{1'b0}};
            start_offset_r     <= FIRST_WORD;
            fill_state_r       <= INVALID_CODE;
            busy               <= 1'b0;
            done               <= 1'b0;
            aborted            <= 1'b0;
            arbiterRequest     <= 1'b0;
            busCommandOut      <= NONE;
            masterAddress      <= {ADDRESS_WIDTH{1'b0}};
            masterReadEnabled  <= 1'b0;
            masterWriteEnabled <= 1'b0;
            cacheOffset        <= FIRST_WORD;
            cacheWriteData     <= 1'b0;
            cacheWriteTag      <= 1'b0;
            cacheWriteState    <= 1'b0;
            cacheStateIn       <= INVALID_CODE;
        end else begin
            state_r            <= state_next_s;
            count_r            <= count_next_s;
            fill_r             <= fill_next_s;
            aborted_r          <= aborted_next_s;
            tag_r              <= tag_next_s;
            victim_tag_r       <= victim_tag_next_s;
            index_r            <= index_next_s;
            start_offset_r     <= start_offset_next_s;
            fill_state_r       <= fill_state_next_s;
            busy               <= busy_s;
            done               <= done_s;
            aborted            <= aborted_s;
            arbiterRequest     <= (bus_command_s != NONE);
            busCommandOut      <= bus_command_s;
            masterAddress      <= master_address_s;
            masterReadEnabled  <= master_read_s;
            masterWriteEnabled <= master_write_s;
            cacheOffset        <= cache_offset_s;
            cacheWriteData     <= cache_write_data_s;
            cacheWriteTag      <= cache_write_tag_s;
            cacheWriteState    <= cache_write_state_s;
            cacheStateIn       <= cache_state_in_s;
        end
    end

endmodule

// File: tb/tb_line_transfer_engine.sv
// Self-checking bench for line_transfer_engine: a bus/memory responder drives grant,
// complete and abort, a monitor logs bus words and cache writes, and each operation
// is compared with the word lists computed from the transfer rules.
module tb_line_transfer_engine;
    import line_transfer_engine_pkg::*;

    localparam int TW = 8;
    localparam int IW = 4;
    localparam int OW = 2;
    localparam int SW = 2;
    localparam int AW = TW + IW + OW;
    localparam int WORDS = 1 << OW;

    typedef struct packed {
        logic [1:0]    cmd;
        logic          we;
        logic          re;
        logic [AW-1:0] addr;
    } xfer_t;

    typedef struct packed {
        logic          tag;
        logic [SW-1:0] st;
    } swr_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, writeBack = 1'b0, fill = 1'b0, abort = 1'b0;
    logic [AW-1:0] address = '0;
    logic [TW-1:0] victimTag = '0;
    logic [SW-1:0] fillState = '0;
    logic arbiterGrant = 1'b1, masterFunctionComplete = 1'b0;
    logic busy, done, aborted, arbiterRequest;
    logic [1:0] busCommandOut;
    logic [AW-1:0] masterAddress;
    logic masterReadEnabled, masterWriteEnabled;
    logic [OW-1:0] cacheOffset;
    logic cacheWriteData, cacheWriteTag, cacheWriteState;
    logic [SW-1:0] cacheStateIn;

    line_transfer_engine #(
        .TAG_WIDTH(TW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW),
        .STATE_WIDTH(SW), .INVALID_STATE(0)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .writeBack(writeBack),
        .fill(fill), .address(address), .victimTag(victimTag), .fillState(fillState),
        .abort(abort), .busy(busy), .done(done), .aborted(aborted),
        .arbiterRequest(arbiterRequest), .arbiterGrant(arbiterGrant),
        .busCommandOut(busCommandOut), .masterAddress(masterAddress),
        .masterReadEnabled(masterReadEnabled), .masterWriteEnabled(masterWriteEnabled),
        .masterFunctionComplete(masterFunctionComplete), .cacheOffset(cacheOffset),
        .cacheWriteData(cacheWriteData), .cacheWriteTag(cacheWriteTag),
        .cacheWriteState(cacheWriteState), .cacheStateIn(cacheStateIn)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    xfer_t got_xfer[$], exp_xfer[$];
    int    got_data[$], exp_data[$];
    swr_t  got_state[$], exp_state[$];
    int    done_count, aborted_count, exp_aborted;

    int cur_abort_word = -1, cur_withhold_word = -1, cur_lat = 1;
    bit rand_grant = 0, noise = 0;
    bit active = 0, pending_start = 0, prev_strobe = 0, abort_sent = 0, after_abort = 0;
    bit withhold_done = 0, done_seen = 0;
    int strobe_cnt = 0, withhold_cnt = 0, wb_done = 0, rd_done = 0;

    function automatic logic [AW-1:0] compose(input int t, input int i, input int o);
        int v;
        v = (t << (IW + OW)) + (i << OW) + o;
        return v[AW-1:0];
    endfunction

    // One clock cycle: sample at the falling edge, check invariants, log, respond.
    task automatic step();
        logic strobe_v;
        xfer_t x;
        swr_t s;
        @(posedge clock);
        @(negedge clock);
        if (pending_start) begin
            active = 1; pending_start = 0; start = 1'b0;
        end
        strobe_v = masterWriteEnabled | masterReadEnabled;
        checks++;
        if (arbiterRequest !== (busCommandOut != NONE)) begin
            errors++; $display("FAIL arb_request: got %b, cmd %0d", arbiterRequest, busCommandOut);
        end
        checks++;
        if (busy !== active) begin
            errors++; $display("FAIL busy: got %b, want %b", busy, active);
        end
        checks++;
        if ((masterWriteEnabled && busCommandOut !== BUS_WRITEBACK) ||
            (masterReadEnabled && busCommandOut !== BUS_READ) ||
            (masterWriteEnabled && masterReadEnabled)) begin
            errors++; $display("FAIL strobe_cmd: we %b re %b cmd %0d", masterWriteEnabled, masterReadEnabled, busCommandOut);
        end
        checks++;
        if (strobe_v && !prev_strobe && arbiterGrant !== 1'b1) begin
            errors++; $display("FAIL strobe_without_grant: strobe rose with grant %b, want 1", arbiterGrant);
        end
        if (after_abort) begin
            checks++;
            if (masterWriteEnabled !== 1'b0 || busCommandOut !== NONE || done !== 1'b1 || aborted !== 1'b1) begin
                errors++; $display("FAIL abort_response: we %b cmd %0d done %b aborted %b, want 0 0 1 1",
                                   masterWriteEnabled, busCommandOut, done, aborted);
            end
            after_abort = 0;
        end
        checks++;
        if ((aborted && !done) || (cacheWriteTag && !cacheWriteState)) begin
            errors++; $display("FAIL pulse_pairing: aborted %b done %b tag %b state %b", aborted, done, cacheWriteTag, cacheWriteState);
        end
        if (!active) begin
            checks++;
            if ((done | cacheWriteData | cacheWriteState | cacheWriteTag) !== 1'b0) begin
                errors++; $display("FAIL idle_quiet: done %b data %b state %b tag %b, want all 0",
                                   done, cacheWriteData, cacheWriteState, cacheWriteTag);
            end
        end
        if (cacheWriteData) got_data.push_back(int'(cacheOffset));
        if (cacheWriteState) begin
            s.tag = cacheWriteTag; s.st = cacheStateIn; got_state.push_back(s);
        end
        if (done) begin
            done_count++;
            if (aborted) aborted_count++;
        end
        // Memory/bus responder.
        abort = 1'b0; masterFunctionComplete = 1'b0; start = 1'b0;
        if (strobe_v) strobe_cnt++; else strobe_cnt = 0;
        if (active && !done && cur_abort_word >= 0 && !abort_sent && masterWriteEnabled && wb_done == cur_abort_word) begin
            abort = 1'b1; masterFunctionComplete = 1'($urandom_range(0, 1));
            abort_sent = 1; after_abort = 1;
        end else if (strobe_v && strobe_cnt >= cur_lat) begin
            masterFunctionComplete = 1'b1;
            x.cmd = busCommandOut; x.we = masterWriteEnabled; x.re = masterReadEnabled; x.addr = masterAddress;
            got_xfer.push_back(x);
            if (masterWriteEnabled) wb_done++; else rd_done++;
        end
        if (noise && busCommandOut == BUS_READ && !abort) abort = 1'($urandom_range(0, 1));
        if (cur_withhold_word >= 0 && !withhold_done && busCommandOut == BUS_READ &&
            rd_done == cur_withhold_word && !strobe_v) begin
            withhold_cnt = 5; withhold_done = 1;
        end
        if (withhold_cnt > 0) begin
            arbiterGrant = 1'b0; withhold_cnt--;
        end else begin
            arbiterGrant = rand_grant ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (active && !done && noise) begin
            start = ($urandom_range(0, 5) == 0);
            writeBack = 1'($urandom); fill = 1'($urandom);
            address = AW'($urandom); victimTag = TW'($urandom); fillState = SW'($urandom);
        end
        if (done) begin
            active = 0; done_seen = 1;
        end
        prev_strobe = strobe_v;
    endtask

    // Issue a request and build the expected bus words and cache writes.
    task automatic start_op(input bit wb, input bit f, input logic [AW-1:0] addr,
                            input logic [TW-1:0] vt, input logic [SW-1:0] fs,
                            input int abort_word, input int withhold_word, input int lat,
                            input bit rg, input bit nz);
        int tag, idx, so, n_wb;
        bit ab;
        xfer_t x;
        swr_t s;
        got_xfer.delete(); exp_xfer.delete(); got_data.delete(); exp_data.delete();
        got_state.delete(); exp_state.delete();
        done_count = 0; aborted_count = 0;
        tag = int'(addr) >> (IW + OW);
        idx = (int'(addr) >> OW) % (1 << IW);
        so  = int'(addr) % WORDS;
        ab  = wb && abort_word >= 0 && abort_word < WORDS;
        exp_aborted = ab ? 1 : 0;
        n_wb = ab ? abort_word : WORDS;
        if (wb) begin
            for (int k = 0; k < n_wb; k++) begin
                x.cmd = BUS_WRITEBACK; x.we = 1'b1; x.re = 1'b0; x.addr = compose(int'(vt), idx, k);
                exp_xfer.push_back(x);
            end
        end
        if (f && !ab) begin
            for (int k = 0; k < WORDS; k++) begin
                x.cmd = BUS_READ; x.we = 1'b0; x.re = 1'b1; x.addr = compose(tag, idx, (so + k) % WORDS);
                exp_xfer.push_back(x);
                exp_data.push_back((so + k) % WORDS);
            end
        end
        if (!ab && f) begin
            s.tag = 1'b1; s.st = fs; exp_state.push_back(s);
        end else if (!ab && wb) begin
            s.tag = 1'b0; s.st = '0; exp_state.push_back(s);
        end
        cur_abort_word = wb ? abort_word : -1; cur_withhold_word = withhold_word; cur_lat = lat;
        rand_grant = rg; noise = nz;
        abort_sent = 0; after_abort = 0; withhold_done = 0; withhold_cnt = 0;
        wb_done = 0; rd_done = 0; strobe_cnt = 0; done_seen = 0;
        start = 1'b1; writeBack = wb; fill = f; address = addr; victimTag = vt; fillState = fs;
        pending_start = 1;
    endtask

    // Run until done (bounded), then compare logs with the expected lists.
    task automatic finish_op(input string name);
        int cyc;
        cyc = 0;
        while (!done_seen && cyc < 400) begin
            step(); cyc++;
        end
        checks++;
        if (!done_seen) begin
            errors++; $display("FAIL %s timeout: no done after %0d cycles", name, cyc);
        end
        checks++;
        if (got_xfer.size() != exp_xfer.size()) begin
            errors++; $display("FAIL %s xfer_count: got %0d, want %0d", name, got_xfer.size(), exp_xfer.size());
        end
        for (int i = 0; i < exp_xfer.size() && i < got_xfer.size(); i++) begin
            checks++;
            if (got_xfer[i] !== exp_xfer[i]) begin
                errors++; $display("FAIL %s xfer[%0d]: got cmd %0d we %b re %b addr %h, want cmd %0d we %b re %b addr %h",
                    name, i, got_xfer[i].cmd, got_xfer[i].we, got_xfer[i].re, got_xfer[i].addr,
                    exp_xfer[i].cmd, exp_xfer[i].we, exp_xfer[i].re, exp_xfer[i].addr);
            end
        end
        checks++;
        if (got_data != exp_data) begin
            errors++; $display("FAIL %s data_writes: got %p, want %p", name, got_data, exp_data);
        end
        checks++;
        if (got_state != exp_state) begin
            errors++; $display("FAIL %s state_writes: got %p, want %p", name, got_state, exp_state);
        end
        checks++;
        if (done_count != 1 || aborted_count != exp_aborted) begin
            errors++; $display("FAIL %s done_pulses: got done %0d aborted %0d, want 1 %0d", name, done_count, aborted_count, exp_aborted);
        end
        step();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++;
        if ({busy, done, aborted, arbiterRequest, busCommandOut, masterReadEnabled, masterWriteEnabled,
             cacheWriteData, cacheWriteTag, cacheWriteState} !== 11'b0 || cacheStateIn !== 2'd0) begin
            errors++; $display("FAIL reset_values: got busy %b done %b cmd %0d state_in %0d, want all 0", busy, done, busCommandOut, cacheStateIn);
        end
        reset = 1'b0;
        step(); step();
    endtask

    task automatic test_writeback_only();
        start_op(1, 0, 14'h2A5C, 8'h3C, 2'd1, -1, -1, 1, 0, 0);
        finish_op("writeback_only");
    endtask

    task automatic test_fill_only();
        start_op(0, 1, compose(8'h5A, 4'h7, 2), 8'h11, 2'd3, -1, -1, 1, 0, 0);
        finish_op("fill_only");
    endtask

    task automatic test_back_to_back();
        start_op(1, 1, compose(8'hC3, 4'h9, 1), 8'h7E, 2'd2, -1, -1, 2, 0, 0);
        finish_op("wb_then_fill");
        start_op(0, 0, 14'h1234, 8'h00, 2'd1, -1, -1, 1, 0, 0);
        finish_op("no_transfer");
    endtask

    task automatic test_abort();
        start_op(1, 1, compose(8'h44, 4'h3, 3), 8'h99, 2'd2, 2, -1, 1, 0, 0);
        finish_op("abort_word2");
        start_op(0, 1, compose(8'h21, 4'hE, 0), 8'h99, 2'd1, -1, -1, 2, 0, 1);
        finish_op("abort_ignored_in_fill");
    endtask

    task automatic test_grant_withhold();
        start_op(0, 1, compose(8'hF0, 4'h5, 3), 8'h00, 2'd3, -1, 2, 1, 0, 0);
        finish_op("grant_withhold");
    endtask

    task automatic test_reset_midfill();
        int cyc;
        start_op(0, 1, compose(8'h66, 4'h2, 1), 8'h00, 2'd3, -1, -1, 3, 0, 0);
        cyc = 0;
        while (!masterReadEnabled && cyc < 50) begin
            step(); cyc++;
        end
        checks++;
        if (masterReadEnabled !== 1'b1) begin
            errors++; $display("FAIL midfill_reach: read strobe %b, want 1", masterReadEnabled);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, aborted, arbiterRequest, busCommandOut, masterReadEnabled, masterWriteEnabled,
             cacheWriteData, cacheWriteTag, cacheWriteState} !== 11'b0 || cacheStateIn !== 2'd0) begin
            errors++; $display("FAIL reset_midfill: got busy %b re %b cmd %0d, want 0 0 0", busy, masterReadEnabled, busCommandOut);
        end
        masterFunctionComplete = 1'b0; arbiterGrant = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        active = 0; pending_start = 0; prev_strobe = 0; after_abort = 0; strobe_cnt = 0;
        abort = 1'b1;
        step();
        start_op(1, 1, compose(8'h0F, 4'hA, 2), 8'hB2, 2'd1, -1, -1, 1, 0, 0);
        finish_op("after_reset");
    endtask

    task automatic test_random();
        bit wb, f;
        int aw, ww;
        for (int n = 0; n < 20; n++) begin
            wb = 1'($urandom_range(0, 1));
            f  = 1'($urandom_range(0, 1));
            aw = (wb && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
            ww = (f && $urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : -1;
            start_op(wb, f, AW'($urandom), TW'($urandom), SW'($urandom), aw, ww,
                     int'($urandom_range(1, 3)), 1, 1);
            finish_op("random");
        end
    endtask

    initial begin
        test_reset();
        test_writeback_only();
        test_fill_only();
        test_back_to_back();
        test_abort();
        test_grant_withhold();
        test_reset_midfill();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_transfer_engine.md
LINE_TRANSFER_ENGINE -- requirements
Module: line_transfer_engine

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 8: tag bits.
REQ-002 SHALL have parameter INDEX_WIDTH, default 4: set-index bits.
REQ-003 SHALL have parameter OFFSET_WIDTH, default 2: word-offset bits; the block holds 2**OFFSET_WIDTH words.
REQ-004 SHALL have parameter STATE_WIDTH, default 2: width of the coherence state.
REQ-005 SHALL have parameter INVALID_STATE, default 0: encoding of the invalid state.
REQ-006 SHALL have these ports (name, direction, width, meaning); clock and reset come first:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request pulse, accepted only in IDLE.
- writeBack  in  1  write back the victim block first (sampled with start).
- fill  in  1  fill the requested block (sampled with start).
- address  in  TAG+INDEX+OFFSET  requested word address (sampled with start).
- victimTag  in  TAG_WIDTH  tag of the victim block (sampled with start).
- fillState  in  STATE_WIDTH  state to install after the fill (sampled with start).
- abort  in  1  snoop-invalidate conflict on the victim block.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at completion.
- aborted  out  1  one-cycle pulse, together with done, when the operation was aborted.
- arbiterRequest  out  1  equals (busCommandOut != NONE).
- arbiterGrant  in  1  bus grant.
- busCommandOut  out  busCommands width  NONE, BUS_WRITEBACK or BUS_READ.
- masterAddress  out  TAG+INDEX+OFFSET  {tag, latched index, word offset}.
- masterReadEnabled / masterWriteEnabled  out  1 each  memory strobes.
- masterFunctionComplete  in  1  memory word done.
- cacheOffset  out  OFFSET_WIDTH  cache data-array word select.
- cacheWriteData / cacheWriteTag / cacheWriteState  out  1 each  cache write strobes.
- cacheStateIn  out  STATE_WIDTH  state written to the cache.

Function
REQ-007 SHALL use states IDLE, WB_GRANT, WB_WAIT, WB_NEXT, FILL_GRANT, FILL_WAIT, FILL_WRITE, UPDATE, FINISH.
REQ-008 SHALL, on start in IDLE, latch all sampled inputs and go to WB_GRANT if writeBack=1, else FILL_GRANT if fill=1, else FINISH.
REQ-009 SHALL ignore start outside IDLE.
REQ-010 SHALL drive busCommandOut = BUS_WRITEBACK in the WB_* states, BUS_READ in the FILL_* states, and NONE otherwise.
REQ-011 SHALL, in a *_GRANT state with arbiterGrant=1, assert the matching strobe next cycle; the strobe SHALL be held until masterFunctionComplete, then drop for at least one cycle.
REQ-012 SHALL stay in a *_GRANT state with no strobe while arbiterGrant=0.
REQ-013 SHALL perform write-back in word order 0..2**OFFSET_WIDTH-1, with masterAddress tag = victimTag.
REQ-014 SHALL perform the fill critical-word-first: word k uses offset (startOffset+k) mod 2**OFFSET_WIDTH, wrapping naturally at the counter width; tag = the requested tag.
REQ-015 SHALL, in FILL_WAIT on masterFunctionComplete, pulse cacheWriteData for one cycle (FILL_WRITE) with cacheOffset equal to the current fill offset.
REQ-016 SHALL, after the last fill word, pulse cacheWriteTag and cacheWriteState with cacheStateIn = fillState (UPDATE).
REQ-017 SHALL, after the last write-back word with fill=0, pulse cacheWriteState with cacheStateIn = INVALID_STATE (UPDATE).
REQ-018 SHALL, after the last write-back word with fill=1, reset the word counter and go to FILL_GRANT without an invalid write.
REQ-019 SHALL go from FINISH to IDLE, pulsing done in FINISH.
REQ-020 SHALL, when abort=1 in any WB_* state, drop the strobes, write no cache state, set busCommandOut to NONE, and go to FINISH with aborted=1.
REQ-021 SHALL ignore abort in all FILL_* states and in IDLE.
REQ-022 SHALL give abort priority over masterFunctionComplete when both occur in the same cycle.

Reset
REQ-023 SHALL, while reset=1 (including mid-transfer), force IDLE, counter=0, busCommandOut=NONE, all strobes, busy, done and aborted=0, and cacheStateIn=INVALID_STATE.
REQ-024 SHALL generate no spurious done or cache write on the first cycle after reset release.

Structure
REQ-025 SHALL import busCommands for NONE/BUS_READ/BUS_WRITEBACK; the state enum SHALL be local to the module.
REQ-026 SHALL be a single module with one sequential process; no sub-module.

Verification
REQ-027 Defaults, writeBack=1 fill=0, grant always, complete 1 cycle after strobe -> 4 writes at offsets 0,1,2,3, then one state write of 0, then done.
REQ-028 fill only, address offset=2, fillState=3 -> read offsets 2,3,0,1; 4 data writes; tag+state write of 3; done.
REQ-029 writeBack=1 fill=1 -> BUS_WRITEBACK for 4 words, then BUS_READ for 4 words, no invalid write, a single done.
REQ-030 abort during write-back word 2 -> strobe drops, no state write, done=aborted=1 for one cycle.
REQ-031 grant withheld for 5 cycles mid-fill -> no strobe, counter holds, and the transfer resumes correctly.
REQ-032 reset asserted during FILL_WAIT -> outputs at reset values immediately; a new start afterwards completes normally.
